// File: rtl/fpu_bus_if_if.sv
// Purpose: host-bus and FPU-core signal bundle for fpu_bus_if (slave = block view, master = driver view).
// Latency: n/a, wires only.
// Backpressure: none; the host strobes and core pulses are not flow controlled.
interface fpu_bus_if_if;
    logic [7:0]  databus_in;
    logic [7:0]  databus_out;
    logic [3:0]  addr;
    logic        cs;
    logic        rd;
    logic        wr;
    logic        end_ack;
    logic        cmd_end;
    logic        busy;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [7:0]  operation;
    logic        start;
    logic        core_done;
    logic [31:0] core_result;

    modport slave (
        input  databus_in, addr, cs, rd, wr, end_ack, core_done, core_result,
        output databus_out, cmd_end, busy, operand_a, operand_b, operation, start
    );

    modport master (
        output databus_in, addr, cs, rd, wr, end_ack, core_done, core_result,
        input  databus_out, cmd_end, busy, operand_a, operand_b, operation, start
    );
endinterface

// File: rtl/fpu_bus_if.sv
// Purpose: 8-bit host register window onto an FPU core (operands, opcode, start, result, IDLE/RUN/DONE control).
// Latency: writes land on the strobe edge; start pulses the cycle after the start write; reads are combinational.
// Backpressure: none; writes while busy and start writes outside IDLE are dropped. Macro FPU_BUS_STATUS_REG_EN adds a status read at 0xD.
module fpu_bus_if (
    input  logic          clk,
    input  logic          arst_n,
    fpu_bus_if_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_wr_q;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [7:0]  r_op;
    logic [31:0] r_res;
    logic        r_start;

    logic        w_wr_evt;
    logic        w_start_wr;
    logic        w_start_acc;
    logic        w_res_load;
    logic        w_cfg_wr_en;
    logic        w_busy;
    logic        w_cmd_end;
    logic [7:0]  w_rd_dat;

    // One write per falling wr strobe: the previous-cycle wr must have been high.
    assign w_wr_evt    = ~bus.cs & ~bus.wr & r_wr_q;
    assign w_start_wr  = w_wr_evt & (bus.addr == 4'h9);
    assign w_busy      = (r_state == S_RUN);
    assign w_cmd_end   = (r_state == S_DONE);
    // Operand/opcode registers are frozen only while the core is computing.
    assign w_cfg_wr_en = w_wr_evt & ~w_busy;

    // Strobe edge detector; resets high so a strobe held through reset release still counts once.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_q <= 1'b1;
        end else begin
            r_wr_q <= bus.wr;
        end
    end

    // Control state register and the one-cycle start pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_acc;
        end
    end

    // Next-state decode; core_done and end_ack only matter in the state that waits for them.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_res_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_wr) begin
                    w_state_nxt = S_RUN;
                    w_start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.core_done) begin
                    w_state_nxt = S_DONE;
                    w_res_load  = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.end_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Host-writable operand and opcode registers, byte addressed little-endian.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_opa <= 32'h0;
            r_opb <= 32'h0;
            r_op  <= 8'h0;
        end else if (w_cfg_wr_en) begin
            case (bus.addr)
                4'h0: r_opa[7:0]   <= bus.databus_in;
                4'h1: r_opa[15:8]  <= bus.databus_in;
                4'h2: r_opa[23:16] <= bus.databus_in;
                4'h3: r_opa[31:24] <= bus.databus_in;
                4'h4: r_opb[7:0]   <= bus.databus_in;
                4'h5: r_opb[15:8]  <= bus.databus_in;
                4'h6: r_opb[23:16] <= bus.databus_in;
                4'h7: r_opb[31:24] <= bus.databus_in;
                4'h8: r_op         <= bus.databus_in;
                default: ;
            endcase
        end
    end

    // Result capture; holds until the next accepted completion.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_res <= 32'h0;
        end else if (w_res_load) begin
            r_res <= bus.core_result;
        end
    end

    // Side-effect-free read mux; bus idles at zero when not being read.
    always_comb begin
        w_rd_dat = 8'h00;
        if (!bus.cs && !bus.rd) begin
            case (bus.addr)
                4'h9: w_rd_dat = r_res[7:0];
                4'hA: w_rd_dat = r_res[15:8];
                4'hB: w_rd_dat = r_res[23:16];
                4'hC: w_rd_dat = r_res[31:24];
`ifdef FPU_BUS_STATUS_REG_EN
                4'hD: w_rd_dat = {6'b0, w_cmd_end, w_busy};
`endif
                default: w_rd_dat = 8'h00;
            endcase
        end
    end

    assign bus.databus_out = w_rd_dat;
    assign bus.cmd_end     = w_cmd_end;
    assign bus.busy        = w_busy;
    assign bus.operand_a   = r_opa;
    assign bus.operand_b   = r_opb;
    assign bus.operation   = r_op;
    assign bus.start       = r_start;

endmodule

// File: tb/tb_fpu_bus_if.sv
// Purpose: scoreboard bench for fpu_bus_if; stimulus queues expectations, a monitor compares them.
// Latency: checks sample 1+ time units after the rising edge.
// Backpressure: n/a.
module tb_fpu_bus_if;

    localparam int K_RD    = 0;
    localparam int K_OPA   = 1;
    localparam int K_OPB   = 2;
    localparam int K_OP    = 3;
    localparam int K_BUSY  = 4;
    localparam int K_CMD   = 5;
    localparam int K_START = 6;
    localparam int K_SCNT  = 7;

`ifdef FPU_BUS_STATUS_REG_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic arst_n;
    fpu_bus_if_if bus_i();

    exp_t sb_q[$];
    event obs_ev;
    int   n_checks;
    int   n_errors;
    int   start_cnt;
    logic prev_start;

    fpu_bus_if dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_i)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Monitor: drains the scoreboard whenever the stimulus marks an observation point.
    initial begin
        forever begin
            @(obs_ev);
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sb_q.pop_front();
                case (e.kind)
                    K_RD:    act = {24'h0, bus_i.databus_out};
                    K_OPA:   act = bus_i.operand_a;
                    K_OPB:   act = bus_i.operand_b;
                    K_OP:    act = {24'h0, bus_i.operation};
                    K_BUSY:  act = {31'h0, bus_i.busy};
                    K_CMD:   act = {31'h0, bus_i.cmd_end};
                    K_START: act = {31'h0, bus_i.start};
                    default: act = start_cnt;
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    // Start-pulse monitor: counts pulses and flags any pulse wider than one cycle.
    always @(negedge clk) begin
        if (bus_i.start === 1'b1) begin
            start_cnt++;
            n_checks++;
            if (prev_start === 1'b1) begin
                n_errors++;
                $display("FAIL start_width: got 2+ cycles expected 1 cycle");
            end
        end
        prev_start = bus_i.start;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        -> obs_ev;
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus_i.cs = 1'b0;
        bus_i.wr = 1'b0;
        bus_i.addr = a;
        bus_i.databus_in = d;
        tick(1);
        bus_i.cs = 1'b1;
        bus_i.wr = 1'b1;
        tick(1);
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        bus_i.cs = 1'b0;
        bus_i.rd = 1'b0;
        bus_i.addr = a;
        #1;
        check(K_RD, {24'h0, exp}, name);
        bus_i.cs = 1'b1;
        bus_i.rd = 1'b1;
        #1;
    endtask

    task automatic core_pulse(input logic [31:0] res);
        bus_i.core_done = 1'b1;
        bus_i.core_result = res;
        tick(1);
        bus_i.core_done = 1'b0;
        bus_i.core_result = 32'h0;
        tick(1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        start_cnt = 0;
        prev_start = 1'b0;
        arst_n = 1'b0;
        bus_i.cs = 1'b1;
        bus_i.rd = 1'b1;
        bus_i.wr = 1'b1;
        bus_i.addr = 4'h0;
        bus_i.databus_in = 8'h00;
        bus_i.end_ack = 1'b0;
        bus_i.core_done = 1'b0;
        bus_i.core_result = 32'h0;

        // Reset state.
        tick(2);
        check(K_BUSY, 32'h0, "rst_busy");
        check(K_CMD,  32'h0, "rst_cmd_end");
        check(K_OPA,  32'h0, "rst_opa");
        check(K_START, 32'h0, "rst_start");
        arst_n = 1'b1;
        tick(1);

        // Operand loading, little-endian bytes.
        bus_write(4'h0, 8'hff);
        bus_write(4'h1, 8'hff);
        bus_write(4'h2, 8'h7f);
        bus_write(4'h3, 8'h7f);
        check(K_OPA, 32'h7f7fffff, "opa_load");
        check(K_OPB, 32'h00000000, "opb_zero");
        bus_write(4'h6, 8'h80);
        bus_write(4'h7, 8'h3f);
        check(K_OPB, 32'h3f800000, "opb_load");
        bus_write(4'h8, 8'h05);
        check(K_OP, 32'h05, "op_load");
        bus_read(4'h0, 8'h00, "rd_unmapped_0");
        bus_read(4'hD, 8'h00, "rd_status_idle");

        // Start command: one-cycle pulse the cycle after the write edge.
        bus_i.cs = 1'b0;
        bus_i.wr = 1'b0;
        bus_i.addr = 4'h9;
        tick(1);
        check(K_START, 32'h1, "start_pulse_hi");
        check(K_BUSY,  32'h1, "busy_after_start");
        bus_i.cs = 1'b1;
        bus_i.wr = 1'b1;
        tick(1);
        check(K_START, 32'h0, "start_pulse_lo");
        check(K_SCNT,  32'd1, "start_count_1");
        bus_read(4'hD, STAT_EN ? 8'h01 : 8'h00, "rd_status_run");

        // Ignored activity while running.
        bus_write(4'h9, 8'h00);
        tick(1);
        check(K_SCNT, 32'd1, "start_in_run_ignored");
        check(K_BUSY, 32'h1, "busy_hold_run");
        bus_write(4'h3, 8'h3f);
        check(K_OPA, 32'h7f7fffff, "opa_locked_run");
        bus_write(4'h8, 8'haa);
        check(K_OP, 32'h05, "op_locked_run");
        bus_i.end_ack = 1'b1;
        tick(1);
        bus_i.end_ack = 1'b0;
        check(K_BUSY, 32'h1, "end_ack_in_run_ignored");

        // Completion.
        core_pulse(32'h5f7fffff);
        check(K_BUSY, 32'h0, "busy_after_done");
        check(K_CMD,  32'h1, "cmd_end_set");
        bus_read(4'h9, 8'hff, "res_b0");
        bus_read(4'hA, 8'hff, "res_b1");
        bus_read(4'hB, 8'h7f, "res_b2");
        bus_read(4'hC, 8'h5f, "res_b3");
        bus_read(4'hD, STAT_EN ? 8'h02 : 8'h00, "rd_status_done");
        bus_i.addr = 4'h9;
        #1;
        check(K_RD, 32'h0, "rd_idle_bus_zero");

        // DONE: core_done and start ignored, config writes allowed.
        core_pulse(32'h11223344);
        bus_read(4'hC, 8'h5f, "res_hold_done");
        bus_write(4'h9, 8'h00);
        tick(1);
        check(K_SCNT, 32'd1, "start_in_done_ignored");
        check(K_CMD,  32'h1, "cmd_end_hold_start");
        bus_write(4'h8, 8'h07);
        check(K_OP, 32'h07, "op_write_done");

        // cmd_end holds until acknowledged.
        tick(20);
        check(K_CMD, 32'h1, "cmd_end_hold_20");
        bus_i.end_ack = 1'b1;
        tick(1);
        bus_i.end_ack = 1'b0;
        check(K_CMD,  32'h0, "cmd_end_cleared");
        check(K_BUSY, 32'h0, "idle_after_ack");

        // core_done in IDLE ignored; result persists.
        core_pulse(32'h12345678);
        check(K_CMD, 32'h0, "core_done_idle_ignored");
        bus_read(4'h9, 8'hff, "res_persist_idle");

        // Long wr strobe gives a single start.
        bus_i.cs = 1'b0;
        bus_i.wr = 1'b0;
        bus_i.addr = 4'h9;
        tick(3);
        bus_i.cs = 1'b1;
        bus_i.wr = 1'b1;
        tick(1);
        check(K_SCNT, 32'd2, "long_strobe_one_start");
        check(K_BUSY, 32'h1, "busy_second_cmd");

        // Asynchronous reset mid-command.
        arst_n = 1'b0;
        #1;
        check(K_BUSY, 32'h0, "arst_busy");
        check(K_CMD,  32'h0, "arst_cmd_end");
        check(K_OPA,  32'h0, "arst_opa");
        check(K_OPB,  32'h0, "arst_opb");
        check(K_OP,   32'h0, "arst_op");
        bus_read(4'hC, 8'h00, "arst_result");
        tick(1);
        arst_n = 1'b1;
        tick(1);
        core_pulse(32'hdeadbeef);
        check(K_CMD,  32'h0, "post_rst_done_ignored");
        check(K_BUSY, 32'h0, "post_rst_idle");
        bus_read(4'h9, 8'h00, "post_rst_result");

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
